// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared ownership states, port ids and default sizes for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int DBITS_DEF      = 32;
    localparam int INDEX_BITS_DEF = 11;
    localparam int LOCK_MAX_DEF   = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } own_t;

    function automatic own_t port_state(input logic port);
        return port ? OWN_P1 : OWN_P0;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: two-way winner selection; an owner wins outright, otherwise the port not served last.
module rr_pick
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] reqs,
    input  logic       last_served,
    input  own_t       owner,
    output logic [1:0] gnt
);

    logic pick1;

    always_comb begin
        pick1 = reqs[1] & (~reqs[0] | (owner == OWN_P1) |
                           ((owner == OWN_NONE) & (last_served == PORT0)));
        gnt   = {pick1, reqs[0] & ~pick1};
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter with lockable ownership in front of a single-ported data memory.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DBITS      = DBITS_DEF,
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  wrtEn0,
    input  logic                  wrtEn1,
    input  logic [INDEX_BITS-1:0] index0,
    input  logic [INDEX_BITS-1:0] index1,
    input  logic [DBITS-1:0]      wdata0,
    input  logic [DBITS-1:0]      wdata1,
    input  logic                  lock0,
    input  logic                  lock1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DBITS-1:0]      rdata0,
    output logic [DBITS-1:0]      rdata1,
    output logic                  mem_wrtEn,
    output logic [INDEX_BITS-1:0] mem_index,
    output logic [DBITS-1:0]      mem_din,
    input  logic [DBITS-1:0]      mem_dout
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    own_t                  state;
    own_t                  owner;
    logic [CW-1:0]         lock_cnt;
    logic                  last_served;
    logic [1:0]            pick;
    logic [1:0]            gnt;
    logic [1:0]            ld_v;
    logic [1:0]            ld_tag;
    logic                  cap;
    logic                  acc;
    logic                  sel;
    logic                  sel_wrt;
    logic                  sel_lock;
    logic [INDEX_BITS-1:0] sel_index;
    logic [DBITS-1:0]      sel_wdata;
    logic                  own_port;
    logic                  own_req;
    logic                  own_lock;
    logic                  own_gnt;
    logic                  other_req;

    // An owner that has used up its lock budget while the other port waits loses its priority.
    always_comb begin
        cap       = (lock_cnt == CW'(LOCK_MAX));
        own_port  = (state == OWN_P1);
        own_req   = own_port ? req1 : req0;
        own_lock  = own_port ? lock1 : lock0;
        other_req = own_port ? req0 : req1;
        owner     = (state != OWN_NONE && cap && other_req) ? OWN_NONE : state;
    end

    rr_pick u_rr_pick (
        .reqs        ({req1, req0}),
        .last_served (last_served),
        .owner       (owner),
        .gnt         (pick)
    );

    always_comb begin
        gnt       = reset ? 2'b00 : pick;
        acc       = |gnt;
        sel       = gnt[1];
        own_gnt   = own_port ? gnt[1] : gnt[0];
        sel_wrt   = sel ? wrtEn1 : wrtEn0;
        sel_lock  = sel ? lock1 : lock0;
        sel_index = sel ? index1 : index0;
        sel_wdata = sel ? wdata1 : wdata0;
    end

    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= OWN_NONE;
            lock_cnt    <= '0;
            last_served <= PORT1;
        end else begin
            if (acc)
                last_served <= sel;
            if (state == OWN_NONE) begin
                if (acc && sel_lock) begin
                    state    <= port_state(sel);
                    lock_cnt <= CW'(1);
                end
            end else if (!own_req || !own_lock || !own_gnt) begin
                state    <= OWN_NONE;
                lock_cnt <= '0;
            end else if (!cap) begin
                lock_cnt <= lock_cnt + CW'(1);
            end
        end
    end

    // Two-deep tag pipeline lines load returns up with the memory's one-cycle read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_wrtEn <= 1'b0;
            mem_index <= '0;
            mem_din   <= '0;
            ld_v      <= '0;
            ld_tag    <= '0;
        end else begin
            mem_wrtEn <= acc & sel_wrt;
            if (acc) begin
                mem_index <= sel_index;
                mem_din   <= sel_wdata;
            end
            ld_v   <= {ld_v[0], acc & ~sel_wrt};
            ld_tag <= {ld_tag[0], sel};
        end
    end

    assign rvalid0 = ld_v[1] & ~ld_tag[1];
    assign rvalid1 = ld_v[1] & ld_tag[1];
    assign rdata0  = rvalid0 ? mem_dout : '0;
    assign rdata1  = rvalid1 ? mem_dout : '0;

endmodule
